// File: rtl/serial_byte_feeder.sv
// serial_byte_feeder
//    Assembles a serial bit stream into WIDTH-bit words. Completed words go
//    into a DEPTH-entry FIFO, and the head word is offered downstream with a
//    valid/ready handshake. Its intended consumer is the bit-counting block.
//
//    Optional build macro: PARITY_CHECK_EN
//       When defined, every word is followed by one even-parity bit.
//       A word whose parity is wrong is dropped, and parity_err pulses for
//       one cycle. When undefined, parity_err is tied low.
//
//    Assembler states
//       state    | meaning
//       A_IDLE   | no bits of the current word held yet
//       A_SHIFT  | 1..WIDTH-1 data bits captured
//       A_PARITY | all data bits held, waiting for the parity bit (macro only)
//
//    Output states
//       state    | meaning
//       O_EMPTY  | FIFO empty, valid_out low
//       O_VALID  | FIFO head presented on data_out, valid_out high

module serial_byte_feeder #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ser_in,
   input  logic                     ser_valid,
   input  logic                     flush,
   output logic [WIDTH-1:0]         data_out,
   output logic                     valid_out,
   input  logic                     ready_in,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     overflow,
   output logic                     parity_err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] A_IDLE   = 2'd0;
   localparam logic [1:0] A_SHIFT  = 2'd1;
`ifdef PARITY_CHECK_EN
   localparam logic [1:0] A_PARITY = 2'd2;
`endif

   localparam logic O_EMPTY = 1'b0;
   localparam logic O_VALID = 1'b1;

   logic [1:0]             a_state_q, a_state_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0]       sr_q, sr_d;
   logic [WIDTH-1:0]       sr_shift;
   logic                   push_req;
   logic [WIDTH-1:0]       push_data;
`ifdef PARITY_CHECK_EN
   logic                   parity_err_q, parity_err_d;
`endif

   logic [WIDTH-1:0]       mem_q [DEPTH];
   logic [WIDTH-1:0]       mem_d [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]       level_q, level_d;
   logic                   o_state_q, o_state_d;
   logic                   full_q, full_d;
   logic                   overflow_q, overflow_d;
   logic                   pop;
   logic                   push_ok;

   // Next shift-register value for one captured bit; the direction is fixed by MSB_FIRST.
   always_comb begin
      sr_shift = sr_q;
      if (MSB_FIRST)
         sr_shift = (sr_q << 1) | WIDTH'(ser_in);
      else
         sr_shift = (sr_q >> 1) | (WIDTH'(ser_in) << (WIDTH - 1));
   end

   // Assembler FSM: count bits, flag a completed word for push, check parity if built in.
   always_comb begin
      a_state_d = a_state_q;
      bit_cnt_d = bit_cnt_q;
      sr_d      = sr_q;
      push_req  = 1'b0;
      push_data = sr_shift;
`ifdef PARITY_CHECK_EN
      parity_err_d = 1'b0;
`endif
      case (a_state_q)
         A_IDLE, A_SHIFT: begin
            if (ser_valid) begin
               sr_d = sr_shift;
               if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                  bit_cnt_d = '0;
`ifdef PARITY_CHECK_EN
                  a_state_d = A_PARITY;
`else
                  a_state_d = A_IDLE;
                  push_req  = 1'b1;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  a_state_d = A_SHIFT;
               end
            end
         end
`ifdef PARITY_CHECK_EN
         A_PARITY: begin
            push_data = sr_q;
            if (ser_valid) begin
               a_state_d = A_IDLE;
               sr_d      = '0;
               // Even parity: the data bits and the parity bit together hold an even count of ones.
               if ((^sr_q) ^ ser_in)
                  parity_err_d = 1'b1;
               else
                  push_req = 1'b1;
            end
         end
`endif
         default: begin
            a_state_d = A_IDLE;
            bit_cnt_d = '0;
         end
      endcase
      // Flush wins over everything, including the bit presented on this cycle.
      if (flush) begin
         a_state_d = A_IDLE;
         bit_cnt_d = '0;
         sr_d      = '0;
         push_req  = 1'b0;
`ifdef PARITY_CHECK_EN
         parity_err_d = 1'b0;
`endif
      end
   end

   // FIFO bookkeeping. A push into a full FIFO is allowed only when a pop frees a slot on the same edge.
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      pop        = (o_state_q == O_VALID) && ready_in && !flush;
      push_ok    = push_req && ((level_q != LVL_W'(DEPTH)) || pop);
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop)
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
      if (push_req && !push_ok)
         overflow_d = 1'b1;
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         overflow_d = 1'b0;
      end
   end

   // Output FSM and registered status follow the post-edge FIFO level.
   always_comb begin
      o_state_d = (level_d != '0) ? O_VALID : O_EMPTY;
      full_d    = (level_d == LVL_W'(DEPTH));
   end

   // State registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_state_q  <= A_IDLE;
         bit_cnt_q  <= '0;
         sr_q       <= '0;
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         o_state_q  <= O_EMPTY;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         a_state_q  <= a_state_d;
         bit_cnt_q  <= bit_cnt_d;
         sr_q       <= sr_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         o_state_q  <= o_state_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef PARITY_CHECK_EN
   // The parity error pulse is registered, so it is high for the one cycle after the bad parity bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         parity_err_q <= 1'b0;
      else
         parity_err_q <= parity_err_d;
   end

   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   // The head slot cannot be overwritten while it is valid and not yet popped, so data_out holds steady.
   assign data_out  = mem_q[rd_ptr_q];
   assign valid_out = (o_state_q == O_VALID);
   assign level     = level_q;
   assign full      = full_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_byte_feeder.sv
// Bench for serial_byte_feeder: an LSB-first instance and an MSB-first instance on shared stimulus.
module tb_serial_byte_feeder;

`ifdef PARITY_CHECK_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ser_in = 1'b0;
   logic       ser_valid = 1'b0;
   logic       flush = 1'b0;
   logic       ready_in = 1'b0;
   logic [7:0] data_out, data_out_m;
   logic       valid_out, valid_out_m;
   logic [2:0] level, level_m;
   logic       full, full_m, overflow, overflow_m, parity_err, parity_err_m;

   logic [7:0] exp_q[$];
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   serial_byte_feeder #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) dut (
      .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid), .flush(flush),
      .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in), .level(level),
      .full(full), .overflow(overflow), .parity_err(parity_err));

   serial_byte_feeder #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid), .flush(flush),
      .data_out(data_out_m), .valid_out(valid_out_m), .ready_in(ready_in), .level(level_m),
      .full(full_m), .overflow(overflow_m), .parity_err(parity_err_m));

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; ser_valid = 1'b0; ser_in = 1'b0; flush = 1'b0; ready_in = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic send_bit(input logic b, input logic rdy);
      @(negedge clk);
      ser_valid = 1'b1; ser_in = b; ready_in = rdy; flush = 1'b0;
   endtask

   task automatic idle();
      @(negedge clk);
      ser_valid = 1'b0; ser_in = 1'b0; ready_in = 1'b0; flush = 1'b0;
   endtask

   // Bits go out LSB of w first; the parity bit follows when parity is built in.
   task automatic send_word(input logic [7:0] w, input logic pop_last);
      for (int i = 0; i < 8; i++)
         send_bit(w[i], pop_last && (i == 7) && !PAR);
      if (PAR)
         send_bit(^w, pop_last);
   endtask

   task automatic drain_one(input string name);
      int n;
      logic [7:0] e;
      n = 0;
      while (!valid_out && n < 50) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (!valid_out) begin
         n_err++;
         $display("FAIL %s_timeout: valid_out=%b after %0d cycles, required 1", name, valid_out, n);
      end else if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL %s_extra: got word %h, required no word", name, data_out);
      end else begin
         e = exp_q.pop_front();
         if (data_out !== e) begin
            n_err++;
            $display("FAIL %s_data: got %h, required %h", name, data_out, e);
         end
         ready_in = 1'b1;
         @(negedge clk);
         ready_in = 1'b0;
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({data_out, valid_out, level, full, overflow, parity_err} !== 14'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got d=%h v=%b l=%0d f=%b o=%b p=%b, required all 0",
                  data_out, valid_out, level, full, overflow, parity_err);
      end
   endtask

   task automatic test_lsb_first();
      do_reset();
      send_word(8'h8D, 1'b0);
      exp_q.push_back(8'h8D);
      n_cmp++;
      if (valid_out !== 1'b0) begin
         n_err++; $display("FAIL t1_early_valid: got %b, required 0", valid_out);
      end
      idle();
      n_cmp++;
      if (valid_out !== 1'b1) begin
         n_err++; $display("FAIL t1_valid: got %b, required 1", valid_out);
      end
      n_cmp++;
      if (data_out !== exp_q[0]) begin
         n_err++; $display("FAIL t1_data: got %h, required %h", data_out, exp_q[0]);
      end
      n_cmp++;
      if (level !== 3'd1) begin
         n_err++; $display("FAIL t1_level: got %0d, required 1", level);
      end
   endtask

   task automatic test_msb_first();
      do_reset();
      send_word(8'h8D, 1'b0);
      idle();
      n_cmp++;
      if (data_out_m !== 8'hB1 || valid_out_m !== 1'b1) begin
         n_err++; $display("FAIL t2_msb_data: got %h v=%b, required b1 v=1", data_out_m, valid_out_m);
      end
      ready_in = 1'b1;
      @(negedge clk);
      ready_in = 1'b0;
      n_cmp++;
      if (valid_out_m !== 1'b0 || level_m !== 3'd0) begin
         n_err++; $display("FAIL t2_pop: got v=%b l=%0d, required v=0 l=0", valid_out_m, level_m);
      end
      n_cmp++;
      if (valid_out !== 1'b0 || level !== 3'd0) begin
         n_err++; $display("FAIL t2_pop_lsb: got v=%b l=%0d, required v=0 l=0", valid_out, level);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int w = 1; w <= 5; w++) begin
         send_word(8'(w), 1'b0);
         if (w <= 4) exp_q.push_back(8'(w));
      end
      idle();
      n_cmp++;
      if (level !== 3'd4 || full !== 1'b1 || overflow !== 1'b1) begin
         n_err++; $display("FAIL t3_full: got l=%0d f=%b o=%b, required l=4 f=1 o=1", level, full, overflow);
      end
      for (int i = 0; i < 4; i++) drain_one("t3_drain");
      n_cmp++;
      if (valid_out !== 1'b0 || level !== 3'd0 || full !== 1'b0 || overflow !== 1'b1) begin
         n_err++; $display("FAIL t3_empty: got v=%b l=%0d f=%b o=%b, required v=0 l=0 f=0 o=1",
                           valid_out, level, full, overflow);
      end
   endtask

   task automatic test_push_pop_full();
      logic [7:0] e;
      do_reset();
      for (int w = 1; w <= 4; w++) begin
         send_word(8'(w), 1'b0);
         exp_q.push_back(8'(w));
      end
      idle();
      e = exp_q.pop_front();
      n_cmp++;
      if (data_out !== e || full !== 1'b1) begin
         n_err++; $display("FAIL t4_head: got %h f=%b, required %h f=1", data_out, full, e);
      end
      exp_q.push_back(8'h05);
      send_word(8'h05, 1'b1);
      idle();
      n_cmp++;
      if (level !== 3'd4 || overflow !== 1'b0 || full !== 1'b1) begin
         n_err++; $display("FAIL t4_simul: got l=%0d o=%b f=%b, required l=4 o=0 f=1", level, overflow, full);
      end
      for (int i = 0; i < 4; i++) drain_one("t4_drain");
      n_cmp++;
      if (valid_out !== 1'b0) begin
         n_err++; $display("FAIL t4_empty: got v=%b, required 0", valid_out);
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int w = 0; w < 5; w++) send_word(8'hA0 + 8'(w), 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      @(negedge clk);
      flush = 1'b1; ser_valid = 1'b1; ser_in = 1'b1; ready_in = 1'b1;
      idle();
      n_cmp++;
      if (level !== 3'd0 || valid_out !== 1'b0 || overflow !== 1'b0 || full !== 1'b0) begin
         n_err++; $display("FAIL t5_flush: got l=%0d v=%b o=%b f=%b, required all 0", level, valid_out, overflow, full);
      end
      exp_q.push_back(8'h00);
      send_word(8'h00, 1'b0);
      idle();
      n_cmp++;
      if (level !== 3'd1) begin
         n_err++; $display("FAIL t5_level: got %0d, required 1", level);
      end
      drain_one("t5_fresh");
   endtask

   task automatic test_parity_and_reset();
`ifdef PARITY_CHECK_EN
      do_reset();
      for (int i = 0; i < 8; i++) send_bit(i < 2, 1'b0);
      send_bit(1'b0, 1'b0);
      idle();
      n_cmp++;
      if (level !== 3'd1 || parity_err !== 1'b0) begin
         n_err++; $display("FAIL t6_par_ok: got l=%0d p=%b, required l=1 p=0", level, parity_err);
      end
      for (int i = 0; i < 8; i++) send_bit(i < 2, 1'b0);
      send_bit(1'b1, 1'b0);
      idle();
      n_cmp++;
      if (parity_err !== 1'b1 || level !== 3'd1 || overflow !== 1'b0) begin
         n_err++; $display("FAIL t6_par_bad: got p=%b l=%0d o=%b, required p=1 l=1 o=0", parity_err, level, overflow);
      end
      idle();
      n_cmp++;
      if (parity_err !== 1'b0) begin
         n_err++; $display("FAIL t6_par_pulse: got %b, required 0", parity_err);
      end
`endif
      do_reset();
      send_word(8'h5A, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b1);
      #1 reset = 1'b1;
      #1;
      n_cmp++;
      if ({data_out, valid_out, level, full, overflow, parity_err} !== 14'd0) begin
         n_err++; $display("FAIL t6_midreset: got d=%h v=%b l=%0d f=%b o=%b p=%b, required all 0",
                           data_out, valid_out, level, full, overflow, parity_err);
      end
      @(negedge clk);
      ser_valid = 1'b0; ready_in = 1'b0;
      reset = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      n_cmp++;
      if (valid_out !== 1'b0) begin
         n_err++; $display("FAIL t6_no_stale: got v=%b, required 0", valid_out);
      end
      exp_q.push_back(8'h3C);
      send_word(8'h3C, 1'b0);
      idle();
      drain_one("t6_after_reset");
   endtask

   initial begin
      test_reset();
      test_lsb_first();
      test_msb_first();
      test_overflow();
      test_push_pop_full();
      test_flush();
      test_parity_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/serial_byte_feeder.md
Name: serial_byte_feeder

Overview:
Upstream stage for the bit-counting block. Assembles a serial bit stream into WIDTH-bit words, buffers completed words in a small FIFO and presents them downstream with a valid/ready handshake. Its data_out/valid_out drive the counter's data_in/valid_in, and the counter's ready_in acknowledge returns to this block's ready_in. Decouples the bursty serial source from the multi-cycle counter.

Parameters:
WIDTH, 8, bits per assembled word
DEPTH, 4, FIFO entries; power of 2, >= 2
MSB_FIRST, 0, 1 = first serial bit lands in data_out[WIDTH-1]; 0 = first bit lands in data_out[0]

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
ser_in  in  1  serial data bit
ser_valid  in  1  ser_in sampled on this edge
flush  in  1  synchronous; discards partial word and all FIFO contents
data_out  out  WIDTH  head-of-FIFO word
valid_out  out  1  data_out holds a word
ready_in  in  1  downstream accept strobe
level  out  $clog2(DEPTH)+1  words currently in FIFO
full  out  1  level == DEPTH
overflow  out  1  sticky; a completed word was dropped
parity_err  out  1  one-cycle pulse (see Optional Feature)

Behaviour:
- Reset: bit counter 0, shift register 0, FIFO pointers 0, level 0, data_out 0, valid_out 0, full 0, overflow 0, parity_err 0. Reset mid-word or mid-handshake discards everything; no word is emitted afterwards.
- Assembler FSM: A_IDLE (no bits held) -> A_SHIFT on first ser_valid; in A_SHIFT each ser_valid shifts one bit and increments bit count. ser_valid low holds state indefinitely (no timeout).
- On the edge capturing bit WIDTH-1: word complete, push attempted on that same edge, bit count -> 0, FSM -> A_IDLE. A ser_valid bit on the following cycle starts the next word; back-to-back ser_valid every cycle is supported without a gap.
- Push rule: accepted if level < DEPTH, or if a pop occurs in the same cycle (level == DEPTH and valid_out & ready_in). Otherwise the word is dropped and overflow set; overflow clears only on reset or flush.
- Output FSM: O_EMPTY (valid_out 0) / O_VALID (valid_out 1). Transfer = valid_out & ready_in on a rising edge. data_out is stable while valid_out is high and no transfer has occurred.
- A word pushed into an empty FIFO appears on data_out/valid_out the next cycle (1-cycle latency from final-bit edge).
- Pop: on transfer, the read pointer advances; valid_out stays high the next cycle if level after the edge > 0. ready_in while valid_out is 0 is ignored.
- Simultaneous push and pop: level unchanged; both pointers advance.
- Pointers wrap modulo DEPTH; level saturates at neither end because the push/pop rules prevent it.
- flush: has priority over push and pop in the same cycle. Clears pointers, level, valid_out, partial word and overflow. The ser_in bit on the flush cycle is discarded.
- full and level are registered and reflect the post-edge state.

Optional Feature:
Macro PARITY_CHECK_EN.
- Defined: each word is followed by one even-parity bit (data bits + parity bit have an even number of 1s). The assembler adds state A_PARITY after bit WIDTH-1; the push happens on the parity-bit edge. On mismatch the word is dropped, parity_err pulses high for 1 cycle, and overflow is unaffected.
- Undefined: no parity bit, A_PARITY is absent, parity_err is tied to 0.

Test Plan:
1. Reset, MSB_FIRST=0, send bits 1,0,1,1,0,0,0,1 on consecutive cycles with ready_in=0 -> valid_out=1 one cycle after the 8th bit, data_out=8'h8D, level=1.
2. Same stream with MSB_FIRST=1 -> data_out=8'hB1; pulse ready_in one cycle -> valid_out=0 next cycle, level=0.
3. Send 5 words (8'h01..8'h05), ready_in=0 -> level=4, full=1, overflow=1 after the 5th word; drain with 4 ready_in pulses -> data_out sequence 01,02,03,04, then valid_out=0.
4. FIFO full with the 5th word completing on the same edge as a ready_in transfer -> no overflow, level stays 4, the word reads out last.
5. After 3 bits of a word plus 2 stored words, assert flush -> level=0, valid_out=0, overflow=0; the next 8 bits form a fresh word with no stale bits.
6. PARITY_CHECK_EN: send 8'h03 + parity 0 -> word accepted; send 8'h03 + parity 1 -> parity_err pulse, level unchanged. Assert reset mid-word -> all outputs 0.
